// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared RV32M funct3 codes, sequencer state encoding and width default
package core_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } seq_state_t;

endpackage

// File: rtl/muldiv_sign_fix.sv
// rtl/muldiv_sign_fix.sv - sign correction and final result select for the muldiv sequencer
module muldiv_sign_fix
  import core_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_hi,
  input  logic [XLEN-1:0] i_lo,
  input  logic            i_neg_q,
  input  logic            i_neg_r,
  input  logic            i_div0,
  output logic [XLEN-1:0] o_result
);

  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;

  // For a zero divisor hi holds |dividend|, so the remainder path returns the dividend unchanged.
  assign w_prod     = {i_hi, i_lo};
  assign w_prod_fix = i_neg_q ? -w_prod : w_prod;
  assign w_quot     = i_div0 ? '1 : (i_neg_q ? -i_lo : i_lo);
  assign w_rem      = i_neg_r ? -i_hi : i_hi;

  always_comb begin
    o_result = w_rem;
    case (i_funct3)
      F3_MUL:                        o_result = w_prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  o_result = w_prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:               o_result = w_quot;
      default:                       o_result = w_rem;
    endcase
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - multi-cycle RV32M MUL/DIV/REM sequencer with pipeline stall
module muldiv_sequencer
  import core_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  output logic [XLEN-1:0] result,
  output logic            busy,
  output logic            done,
  output logic            stall
);

  localparam int CW = $clog2(XLEN);

  seq_state_t      r_state;
  seq_state_t      w_next;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_op1;
  logic [XLEN-1:0] r_op2;
  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_result;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_div0;
  logic [CW-1:0]   r_count;

  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_s1;
  logic            w_s2;
  logic [XLEN-1:0] w_abs1;
  logic [XLEN-1:0] w_abs2;
  logic            w_div0;
  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_rem_shift;
  logic [XLEN:0]   w_diff;
  logic [XLEN-1:0] w_fix_result;

  assign w_a_signed = (r_funct3 == F3_MULH) || (r_funct3 == F3_MULHSU) ||
                      (r_funct3 == F3_DIV)  || (r_funct3 == F3_REM);
  assign w_b_signed = (r_funct3 == F3_MULH) || (r_funct3 == F3_DIV) || (r_funct3 == F3_REM);
  assign w_s1       = w_a_signed & r_op1[XLEN-1];
  assign w_s2       = w_b_signed & r_op2[XLEN-1];
  assign w_abs1     = w_s1 ? -r_op1 : r_op1;
  assign w_abs2     = w_s2 ? -r_op2 : r_op2;
  assign w_div0     = r_funct3[2] & (r_op2 == '0);

  // Multiply: add multiplicand into the high half when the multiplier LSB is set, then shift right.
  assign w_sum       = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
  // Divide: shift the next dividend bit into the partial remainder and trial-subtract.
  assign w_rem_shift = {r_hi, r_lo[XLEN-1]};
  assign w_diff      = w_rem_shift - {1'b0, r_mcand};

  muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .i_funct3 (r_funct3),
    .i_hi     (r_hi),
    .i_lo     (r_lo),
    .i_neg_q  (r_neg_q),
    .i_neg_r  (r_neg_r),
    .i_div0   (r_div0),
    .o_result (w_fix_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = start ? S_LOAD : S_IDLE;
      S_LOAD:  w_next = w_div0 ? S_FIX : S_CALC;
      S_CALC:  w_next = (r_count == '0) ? S_FIX : S_CALC;
      S_FIX:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    stall = 1'b0;
    case (r_state)
      S_IDLE:  stall = start;
      S_DONE:  busy  = 1'b1;
      default: begin
        busy  = 1'b1;
        stall = 1'b1;
      end
    endcase
    if (r_state == S_DONE) done = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_funct3 <= '0;
      r_op1    <= '0;
      r_op2    <= '0;
      r_mcand  <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_result <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_count  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_funct3 <= funct3;
            r_op1    <= operand1;
            r_op2    <= operand2;
          end
        end
        S_LOAD: begin
          r_mcand <= w_abs2;
          r_lo    <= w_abs1;
          r_hi    <= w_div0 ? w_abs1 : '0;
          r_neg_q <= w_s1 ^ w_s2;
          r_neg_r <= w_s1;
          r_div0  <= w_div0;
          r_count <= CW'(XLEN - 1);
        end
        S_CALC: begin
          if (r_funct3[2]) begin
            r_hi <= w_diff[XLEN] ? w_rem_shift[XLEN-1:0] : w_diff[XLEN-1:0];
            r_lo <= {r_lo[XLEN-2:0], ~w_diff[XLEN]};
          end else begin
            r_hi <= w_sum[XLEN:1];
            r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
          end
          if (r_count != '0) r_count <= r_count - CW'(1);
        end
        S_FIX: r_result <= w_fix_result;
        default: ;
      endcase
    end
  end

  assign result = r_result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - self-checking bench for muldiv_sequencer against an arithmetic model
module tb_muldiv_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic [31:0] result;
  logic        busy;
  logic        done;
  logic        stall;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .funct3   (funct3),
    .operand1 (operand1),
    .operand2 (operand2),
    .result   (result),
    .busy     (busy),
    .done     (done),
    .stall    (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input bit noise);
    logic [31:0] exp_r;
    int exp_c;
    int cyc;
    bit seen;
    bit stall_ok;
    exp_r = ref_result(f3, a, b);
    exp_c = (f3[2] && b == 32'd0) ? 3 : 35;
    @(negedge clk);
    start = 1'b1; funct3 = f3; operand1 = a; operand2 = b;
    #1;
    stall_ok = (stall === 1'b1);
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      start    = noise ? 1'($urandom) : 1'b0;
      funct3   = 3'($urandom);
      operand1 = $urandom;
      operand2 = $urandom;
      #1;
      if (done === 1'b1) seen = 1'b1;
      else if (stall !== 1'b1) stall_ok = 1'b0;
    end
    chk({tag, " done_cycle"}, seen ? cyc : -1, exp_c);
    chk({tag, " result"}, result, exp_r);
    chk({tag, " stall_in_done"}, {31'b0, stall}, 32'd0);
    chk({tag, " stall_while_busy"}, {31'b0, stall_ok}, 32'd1);
    start = 1'b0;
    @(negedge clk);
    #1;
    chk({tag, " idle_after_done"}, {30'b0, busy, done}, 32'd0);
    chk({tag, " result_held"}, result, exp_r);
  endtask

  initial begin
    int cyc;
    bit done_seen;
    rst_n = 1'b0; start = 1'b0; funct3 = 3'd0; operand1 = 32'd0; operand2 = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset stall", {31'b0, stall}, 32'd0);
    chk("reset result", result, 32'd0);
    rst_n = 1'b1;

    run_op("mul_7x6",        3'd0, 32'd7,           32'd6,           1'b0);
    chk("mul_7x6 literal", result, 32'h0000_002A);
    run_op("mulh_m1xm1",     3'd1, 32'hFFFF_FFFF,   32'hFFFF_FFFF,   1'b0);
    run_op("mulhu_m1xm1",    3'd3, 32'hFFFF_FFFF,   32'hFFFF_FFFF,   1'b0);
    chk("mulhu literal", result, 32'hFFFF_FFFE);
    run_op("div_m7_2",       3'd4, 32'hFFFF_FFF9,   32'd2,           1'b0);
    chk("div literal", result, 32'hFFFF_FFFD);
    run_op("rem_m7_2",       3'd6, 32'hFFFF_FFF9,   32'd2,           1'b0);
    chk("rem literal", result, 32'hFFFF_FFFF);
    run_op("divu_by0",       3'd5, 32'd100,         32'd0,           1'b0);
    run_op("remu_by0",       3'd7, 32'd100,         32'd0,           1'b0);
    chk("remu_by0 literal", result, 32'h0000_0064);
    run_op("div_by0_neg",    3'd4, 32'hFFFF_FF00,   32'd0,           1'b0);
    run_op("rem_by0_neg",    3'd6, 32'hFFFF_FF00,   32'd0,           1'b0);
    run_op("div_ovf",        3'd4, 32'h8000_0000,   32'hFFFF_FFFF,   1'b0);
    run_op("rem_ovf",        3'd6, 32'h8000_0000,   32'hFFFF_FFFF,   1'b0);
    run_op("mulhsu_neg",     3'd2, 32'hFFFF_FFFE,   32'hFFFF_FFFF,   1'b0);
    run_op("mul_noise",      3'd0, 32'h1234_5678,   32'h9ABC_DEF0,   1'b1);

    // Abort a MUL with reset at cycle 10; no done may follow.
    @(negedge clk);
    start = 1'b1; funct3 = 3'd0; operand1 = 32'd7; operand2 = 32'd6;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("abort busy", {31'b0, busy}, 32'd0);
    chk("abort done", {31'b0, done}, 32'd0);
    chk("abort result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 1'b0;
    for (cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) done_seen = 1'b1;
    end
    chk("abort no_done", {31'b0, done_seen}, 32'd0);

    for (int i = 0; i < 40; i++) begin
      run_op($sformatf("rand%0d", i), 3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
             (i % 2) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
